// File: rtl/set_assoc_cache.sv
// Purpose : N-way set-associative write-through data cache with true-LRU and req/ack refill.
// Latency : read hit completes in the cycle after the lookup edge; misses and writes add memory round trip.
// Backpres: single outstanding request; busy_o high while not IDLE, memory waits on mem_ack_i indefinitely.
//
// Ports: clk/rst (sync active-high); cpu_req_i/cpu_we_i/addr_i/wdata_i request side;
//        rdata_o/cpu_ready_o/hit_o/busy_o completion side; mem_* word-aligned memory handshake;
//        hit_count_o/miss_count_o read-lookup statistics, live only when CACHE_STATS_EN is defined
//        (tied to 0 otherwise).
module set_assoc_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_WIDTH  = 3,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  cpu_ready_o,
  output logic                  hit_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);

  localparam int SETS      = 1 << SET_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;
  localparam int AGE_WIDTH = $clog2(WAYS);
  localparam logic [AGE_WIDTH-1:0] AGE_LRU = AGE_WIDTH'(WAYS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_MEM} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_we_q, req_we_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic                  lk_hit_q, lk_hit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  hit_q, hit_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Line storage, indexed [set][way].
  logic                  valid_q [SETS][WAYS];
  logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [AGE_WIDTH-1:0]  age_q   [SETS][WAYS];

  logic [SET_WIDTH-1:0]  req_set;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  lk_hit;
  logic [AGE_WIDTH-1:0]  lk_way;
  logic [AGE_WIDTH-1:0]  vic_way;
  logic                  touch_en;
  logic [AGE_WIDTH-1:0]  touch_way;
  logic [AGE_WIDTH-1:0]  touch_age;
  logic                  fill_en;
  logic                  wr_en;
  logic                  unused_addr_lsb;

  assign req_set = req_addr_q[SET_WIDTH+1:2];
  assign req_tag = req_addr_q[ADDR_WIDTH-1:SET_WIDTH+2];
  // Byte offset never reaches memory; addresses are forced word aligned.
  assign unused_addr_lsb = ^req_addr_q[1:0];

  // Tag compare across the set; tags are unique per set so at most one way matches.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        lk_hit = 1'b1;
        lk_way = AGE_WIDTH'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, else the LRU way (age WAYS-1).
  always_comb begin
    logic found;
    found   = 1'b0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_set][w]) begin
        found   = 1'b1;
        vic_way = AGE_WIDTH'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_set][w] == AGE_LRU) begin
          vic_way = AGE_WIDTH'(w);
        end
      end
    end
  end

  assign touch_age = age_q[req_set][touch_way];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    lk_hit_d    = lk_hit_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    hit_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    touch_en    = 1'b0;
    touch_way   = lk_way;
    fill_en     = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          req_addr_d  = addr_i;
          req_we_d    = cpu_we_i;
          req_wdata_d = wdata_i;
          state_d     = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        lk_hit_d = lk_hit;
        if (!req_we_q && lk_hit) begin
          rdata_d  = data_q[req_set][lk_way];
          hit_d    = 1'b1;
          ready_d  = 1'b1;
          touch_en = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          // Read miss or any write: go to memory (write-through, no write allocate).
          mem_req_d   = 1'b1;
          mem_we_d    = req_we_q;
          mem_addr_d  = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = req_wdata_q;
          if (req_we_q && lk_hit) begin
            wr_en    = 1'b1;
            touch_en = 1'b1;
          end
          state_d = ST_MEM;
        end
      end

      ST_MEM: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
          if (!mem_we_q) begin
            fill_en   = 1'b1;
            touch_en  = 1'b1;
            touch_way = vic_way;
            rdata_d   = mem_rdata_i;
            hit_d     = 1'b0;
          end else begin
            hit_d = lk_hit_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      lk_hit_q    <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      lk_hit_q    <= lk_hit_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Line arrays. Reset wins over any pending fill/touch, which aborts the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_WIDTH'(w);
        end
      end
    end else begin
      if (fill_en) begin
        valid_q[req_set][vic_way] <= 1'b1;
        tag_q[req_set][vic_way]   <= req_tag;
        data_q[req_set][vic_way]  <= mem_rdata_i;
      end
      if (wr_en) begin
        data_q[req_set][lk_way] <= req_wdata_q;
      end
      // True-LRU touch: younger ways age by one, the touched way becomes MRU.
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_WIDTH'(w) == touch_way) begin
            age_q[req_set][w] <= '0;
          end else if (age_q[req_set][w] < touch_age) begin
            age_q[req_set][w] <= age_q[req_set][w] + AGE_WIDTH'(1);
          end
        end
      end
    end
  end

  assign rdata_o     = rdata_q;
  assign cpu_ready_o = ready_q;
  assign hit_o       = hit_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Only read lookups count; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_LOOKUP && !req_we_q) begin
      if (lk_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache (WAYS=2, 8 sets, 32-bit).
// Completions are checked by a scoreboard; scenario tasks check timing, memory traffic and reset.
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        cpu_ready_o;
  logic        hit_o;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  set_assoc_cache dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .cpu_ready_o  (cpu_ready_o),
    .hit_o        (hit_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [31:0] rd;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_rd;
  int          mem_req_count;
  int          ack_delay;
  bit          mem_auto;
  int          late_ack_req;
  int          late_ack_done;
  logic        last_mem_we;
  logic [31:0] last_mem_addr;
  logic [31:0] last_mem_wdata;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Drive one request, push its expected completion, wait for cpu_ready_o.
  // lat = negedges after the request edge until ready is seen.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_hit, input logic [31:0] exp_rd,
                       input bit no_wait, output int lat);
    exp_t e;
    if (!we) last_rd = exp_rd;
    e.hit = exp_hit;
    e.rd  = last_rd;
    sb.push_back(e);
    if (!no_wait) @(negedge clk);
    cpu_req_i = 1'b1;
    cpu_we_i  = we;
    addr_i    = a;
    wdata_i   = d;
    @(negedge clk);
    cpu_req_i = 1'b0;
    lat = 1;
    while (!cpu_ready_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_ready_o) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout addr=%h waited=%0d cycles", a, lat);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 10;
    if (rdata_o     !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    if (cpu_ready_o !== 1'b0)  begin failures++; $display("FAIL reset_ready got=%b exp=0", cpu_ready_o); end
    if (hit_o       !== 1'b0)  begin failures++; $display("FAIL reset_hit got=%b exp=0", hit_o); end
    if (busy_o      !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    if (mem_req_o   !== 1'b0)  begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
    if (mem_we_o    !== 1'b0)  begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we_o); end
    if (mem_addr_o  !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
    if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata_o); end
    if (hit_count_o !== 32'h0) begin failures++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count_o); end
    if (miss_count_o!== 32'h0) begin failures++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count_o); end
  endtask

  task automatic test_read_miss_hit();
    int lat;
    int c0;
    mem_model[32'h10] = 32'hDEAD_BEEF;
    c0 = mem_req_count;
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, lat);
    checks++;
    if (mem_req_count - c0 !== 1) begin failures++; $display("FAIL miss_mem_req got=%0d exp=1", mem_req_count - c0); end
    c0 = mem_req_count;
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, lat);
    checks += 2;
    if (lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    if (mem_req_count !== c0) begin failures++; $display("FAIL hit_no_mem_req got=%0d exp=%0d", mem_req_count, c0); end
  endtask

  task automatic test_lru();
    int lat;
    issue(1'b0, 32'h30, 32'h0, 1'b0, mem_read(32'h30), 1'b0, lat);
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF,    1'b0, lat);
    issue(1'b0, 32'h50, 32'h0, 1'b0, mem_read(32'h50), 1'b0, lat);  // evicts 0x30
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF,    1'b0, lat);
    issue(1'b0, 32'h30, 32'h0, 1'b0, mem_read(32'h30), 1'b0, lat);  // evicts 0x50
  endtask

  task automatic test_write_hit();
    int lat;
    issue(1'b1, 32'h10, 32'h1234_5678, 1'b1, 32'h0, 1'b0, lat);
    checks += 3;
    if (last_mem_we    !== 1'b1)         begin failures++; $display("FAIL wr_hit_mem_we got=%b exp=1", last_mem_we); end
    if (last_mem_addr  !== 32'h10)       begin failures++; $display("FAIL wr_hit_mem_addr got=%h exp=00000010", last_mem_addr); end
    if (last_mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_hit_mem_wdata got=%h exp=12345678", last_mem_wdata); end
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_5678, 1'b0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL wr_then_read_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_write_miss();
    int lat;
    issue(1'b1, 32'h72, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, lat);
    checks += 3;
    if (last_mem_we    !== 1'b1)          begin failures++; $display("FAIL wr_miss_mem_we got=%b exp=1", last_mem_we); end
    if (last_mem_addr  !== 32'h70)        begin failures++; $display("FAIL wr_miss_mem_addr got=%h exp=00000070", last_mem_addr); end
    if (last_mem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_miss_mem_wdata got=%h exp=a5a5a5a5", last_mem_wdata); end
    issue(1'b0, 32'h70, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0, lat);     // evicts 0x30
  endtask

  task automatic test_back_to_back();
    int lat;
    int c0;
    c0 = mem_req_count;
    issue(1'b0, 32'h70, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0, lat);
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_5678, 1'b1, lat);
    checks += 2;
    if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    if (mem_req_count !== c0) begin failures++; $display("FAIL b2b_no_mem_req got=%0d exp=%0d", mem_req_count, c0); end
  endtask

  task automatic test_reset_in_mem();
    int n;
    int lat;
    mem_auto = 1'b0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; addr_i = 32'h90; wdata_i = 32'h0;
    @(negedge clk);
    cpu_req_i = 1'b0;
    n = 0;
    while (!mem_req_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rim_mem_req_before got=%b exp=1", mem_req_o); end
    repeat (2) @(negedge clk);
    do_reset();
    checks += 2;
    if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rim_mem_req_after got=%b exp=0", mem_req_o); end
    if (busy_o    !== 1'b0) begin failures++; $display("FAIL rim_busy_after got=%b exp=0", busy_o); end
    late_ack_req++;
    mem_auto = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ready_o !== 1'b0 || busy_o !== 1'b0) n++;
    end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL rim_late_ack_ignored got=%0d active cycles exp=0", n); end
    issue(1'b0, 32'h90, 32'h0, 1'b0, mem_read(32'h90), 1'b0, lat);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678,    1'b0, lat);  // valid bits were cleared
  endtask

  task automatic test_stats();
    int lat;
    logic [31:0] exp_h;
    logic [31:0] exp_m;
`ifdef CACHE_STATS_EN
    exp_h = 32'd2;
    exp_m = 32'd1;
`else
    exp_h = 32'd0;
    exp_m = 32'd0;
`endif
    do_reset();
    issue(1'b0, 32'hA0, 32'h0,         1'b0, mem_read(32'hA0), 1'b0, lat);
    issue(1'b0, 32'hA0, 32'h0,         1'b1, mem_read(32'hA0), 1'b0, lat);
    issue(1'b0, 32'hA0, 32'h0,         1'b1, mem_read(32'hA0), 1'b0, lat);
    issue(1'b1, 32'hA0, 32'hCAFE_F00D, 1'b1, 32'h0,            1'b0, lat);
    checks += 2;
    if (hit_count_o  !== exp_h) begin failures++; $display("FAIL stats_hit got=%0d exp=%0d", hit_count_o, exp_h); end
    if (miss_count_o !== exp_m) begin failures++; $display("FAIL stats_miss got=%0d exp=%0d", miss_count_o, exp_m); end
  endtask

  initial begin
    rst = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    mem_req_count = 0; ack_delay = 3; mem_auto = 1'b1;
    late_ack_req = 0; late_ack_done = 0; last_rd = '0;
    last_mem_we = 1'b0; last_mem_addr = '0; last_mem_wdata = '0;

    fork
      // Scoreboard: pop and compare on every completion pulse.
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && cpu_ready_o) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL unexpected_ready hit=%b rdata=%h", hit_o, rdata_o);
            end else begin
              e = sb.pop_front();
              if (hit_o !== e.hit || rdata_o !== e.rd) begin
                failures++;
                $display("FAIL completion got hit=%b rdata=%h exp hit=%b rdata=%h",
                         hit_o, rdata_o, e.hit, e.rd);
              end
            end
          end
        end
      end
      // Memory responder: ack ack_delay cycles after mem_req_o rises.
      begin
        int wait_cnt;
        logic prev_req;
        wait_cnt = 0;
        prev_req = 1'b0;
        forever begin
          @(posedge clk);
          #1;
          mem_ack_i = 1'b0;
          if (mem_req_o && !prev_req) mem_req_count++;
          prev_req = mem_req_o;
          if (late_ack_req != late_ack_done) begin
            late_ack_done = late_ack_req;
            mem_ack_i     = 1'b1;
            mem_rdata_i   = 32'hBAD0_BAD0;
          end else if (mem_req_o && mem_auto) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
              wait_cnt       = 0;
              mem_ack_i      = 1'b1;
              last_mem_we    = mem_we_o;
              last_mem_addr  = mem_addr_o;
              last_mem_wdata = mem_wdata_o;
              if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
              else          mem_rdata_i = mem_read(mem_addr_o);
            end
          end else begin
            wait_cnt = 0;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    test_reset();
    test_read_miss_hit();
    test_lru();
    test_write_hit();
    test_write_miss();
    test_back_to_back();
    test_reset_in_mem();
    test_stats();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
